pwl_segment_select: RTL and testbench

Parametrised, pipelined piecewise-linear segment selector for the activation-approximation path. It compares a sign-magnitude input against a run-time-loadable ascending breakpoint table and returns the slope `m` and intercept `c` of the matching segment. The input sample travels alongside them so the downstream multiply-add stage can form `m*x + c`. It uses valid/ready handshakes on both sides and sits between the accumulator output and the PWL MAC.

---
 rtl/pwl_pkg.sv | 58 +++++
 rtl/pwl_sm_compare.sv | 19 +
 rtl/pwl_segment_select.sv | 142 ++++++++++++++
 tb/tb_pwl_segment_select.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_pkg.sv
// pwl_pkg -- shared definitions for the piecewise-linear segment selector.
//
// Contents:
//   PWL_SEL_BP / PWL_SEL_M / PWL_SEL_C : cfg_sel encodings (3 is reserved)
//   PWL_MAX_W                          : widest sign-magnitude value supported
//   pwl_sm_norm(x, w)                  : maps -0 to +0 for a w-bit value
//   pwl_sm_lt(a, b, w)                 : sign-magnitude a < b for w-bit values
//
// Both functions work on the low w bits of a PWL_MAX_W-wide argument.
// Callers zero-extend their operands into that width and truncate the result.
package pwl_pkg;

  localparam logic [1:0] PWL_SEL_BP = 2'd0;
  localparam logic [1:0] PWL_SEL_M  = 2'd1;
  localparam logic [1:0] PWL_SEL_C  = 2'd2;

  localparam int PWL_MAX_W = 64;

  function automatic logic [PWL_MAX_W-1:0] pwl_sm_norm(input logic [PWL_MAX_W-1:0] x,
                                                       input int w);
    logic [PWL_MAX_W-1:0] mag_mask;
    logic                 sign;
    mag_mask = (PWL_MAX_W'(1) << (w - 1)) - PWL_MAX_W'(1);
    sign     = ((x >> (w - 1)) & PWL_MAX_W'(1)) != '0;
    if (sign && ((x & mag_mask) == '0)) begin
      return '0;
    end
    return x;
  endfunction

  function automatic logic pwl_sm_lt(input logic [PWL_MAX_W-1:0] a,
                                     input logic [PWL_MAX_W-1:0] b,
                                     input int w);
    logic [PWL_MAX_W-1:0] mag_mask;
    logic [PWL_MAX_W-1:0] ma;
    logic [PWL_MAX_W-1:0] mb;
    logic                 sa;
    logic                 sb;
    mag_mask = (PWL_MAX_W'(1) << (w - 1)) - PWL_MAX_W'(1);
    ma = a & mag_mask;
    mb = b & mag_mask;
    sa = ((a >> (w - 1)) & PWL_MAX_W'(1)) != '0;
    sb = ((b >> (w - 1)) & PWL_MAX_W'(1)) != '0;
    // Both zero (either sign) compare equal, so never less-than.
    if ((ma == '0) && (mb == '0)) begin
      return 1'b0;
    end
    if (sa != sb) begin
      return sa;
    end
    // Among negatives the larger magnitude is the smaller value.
    if (!sa) begin
      return ma < mb;
    end
    return ma > mb;
  endfunction

endpackage

// File: rtl/pwl_sm_compare.sv
// pwl_sm_compare -- one sign-magnitude less-than comparator.
//
// Ports:
//   a  [DATA_W-1:0] in  : left operand, sign-magnitude
//   b  [DATA_W-1:0] in  : right operand, sign-magnitude
//   lt              out : 1 when a < b in sign-magnitude order
module pwl_sm_compare
  import pwl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lt
);

  assign lt = pwl_sm_lt(PWL_MAX_W'(a), PWL_MAX_W'(b), DATA_W);

endmodule

// File: rtl/pwl_segment_select.sv
// pwl_segment_select -- pipelined piecewise-linear segment selector.
//
// Compares a sign-magnitude sample against an ascending breakpoint table and
// returns slope/intercept of the matching segment along with the sample.
// Two register stages: S1 holds the normalised sample and segment index,
// S2 holds the output sample and the m/c table read.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid / in_ready / in_data     : sample input handshake
//   out_valid / out_ready             : result handshake
//   out_data, out_m, out_c            : normalised sample, slope, intercept
//   out_seg                           : segment index (only with PWL_SEG_IDX_EN)
//   cfg_we, cfg_sel, cfg_addr,
//   cfg_wdata, cfg_ready              : table write port, only while pipeline empty
//
// Build option: define PWL_SEG_IDX_EN to add the out_seg output.
module pwl_segment_select
  import pwl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NSEG   = 9,
  parameter int AW     = $clog2(NSEG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_m,
  output logic [DATA_W-1:0] out_c,
`ifdef PWL_SEG_IDX_EN
  output logic [AW-1:0]     out_seg,
`endif
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_ready
);

  logic [DATA_W-1:0] bp_reg [NSEG-1];
  logic [DATA_W-1:0] m_reg  [NSEG];
  logic [DATA_W-1:0] c_reg  [NSEG];

  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic [AW-1:0]     s1_seg_reg;

  logic              s2_load;
  logic              s1_load;
  logic              cfg_write;
  logic [DATA_W-1:0] data_norm;
  logic [NSEG-2:0]   flag;
  logic [AW-1:0]     seg_next;

  assign s2_load   = !out_valid || out_ready;
  assign s1_load   = !s1_valid_reg || s2_load;
  assign in_ready  = !cfg_we && s1_load;
  assign cfg_ready = !s1_valid_reg && !out_valid;
  assign cfg_write = cfg_we && cfg_ready;

  assign data_norm = DATA_W'(pwl_sm_norm(PWL_MAX_W'(in_data), DATA_W));

  // Tables: addresses past the end never match, and cfg_sel = 3 matches
  // no table, so both are silently ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSEG - 1; i++) bp_reg[i] <= '0;
      for (int i = 0; i < NSEG; i++) begin
        m_reg[i] <= '0;
        c_reg[i] <= '0;
      end
    end else if (cfg_write) begin
      for (int i = 0; i < NSEG - 1; i++) begin
        if ((cfg_sel == PWL_SEL_BP) && (cfg_addr == AW'(i))) bp_reg[i] <= cfg_wdata;
      end
      for (int i = 0; i < NSEG; i++) begin
        if ((cfg_sel == PWL_SEL_M) && (cfg_addr == AW'(i))) m_reg[i] <= cfg_wdata;
        if ((cfg_sel == PWL_SEL_C) && (cfg_addr == AW'(i))) c_reg[i] <= cfg_wdata;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSEG - 1; gi++) begin : g_cmp
      pwl_sm_compare #(.DATA_W(DATA_W)) u_cmp (
        .a  (data_norm),
        .b  (bp_reg[gi]),
        .lt (flag[gi])
      );
    end
  endgenerate

  // Lowest set flag wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    seg_next = AW'(NSEG - 1);
    for (int i = NSEG - 2; i >= 0; i--) begin
      if (flag[i]) seg_next = AW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_seg_reg   <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_data_reg <= data_norm;
        s1_seg_reg  <= seg_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_m     <= '0;
      out_c     <= '0;
`ifdef PWL_SEG_IDX_EN
      out_seg   <= '0;
`endif
    end else if (s2_load) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data <= s1_data_reg;
        out_m    <= m_reg[s1_seg_reg];
        out_c    <= c_reg[s1_seg_reg];
`ifdef PWL_SEG_IDX_EN
        out_seg  <= s1_seg_reg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwl_segment_select.sv
module tb_pwl_segment_select;
  import pwl_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_m;
  logic [15:0] out_c;
`ifdef PWL_SEG_IDX_EN
  logic [3:0]  out_seg;
`endif
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ready;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] m;
    logic [15:0] c;
    logic [3:0]  seg;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [15:0] bp_t [8];
  logic [15:0] m_t  [9];
  logic [15:0] c_t  [9];

  pwl_segment_select #(.DATA_W(16), .NSEG(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_m     (out_m),
    .out_c     (out_c),
`ifdef PWL_SEG_IDX_EN
    .out_seg   (out_seg),
`endif
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: sign-magnitude to plain integer, then ordinary comparison.
  function automatic int sm_val(input logic [15:0] x);
    logic [14:0] mag;
    mag = x[14:0];
    return x[15] ? -int'(mag) : int'(mag);
  endfunction

  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    int   v;
    v = sm_val(x);
    e.seg = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v < sm_val(bp_t[i])) e.seg = 4'(i);
    end
    e.d = (x == 16'h8000) ? 16'h0000 : x;
    e.m = m_t[e.seg];
    e.c = c_t[e.seg];
    return e;
  endfunction

  task automatic clear_model_tables;
    for (int i = 0; i < 8; i++) bp_t[i] = 16'h0;
    for (int i = 0; i < 9; i++) begin
      m_t[i] = 16'h0;
      c_t[i] = 16'h0;
    end
  endtask

  // Table write with an empty pipeline; entered and left just after a negedge.
  task automatic do_cfg(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
    in_valid  = 1'b0;
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (sel == PWL_SEL_BP && addr < 4'd8) bp_t[addr[2:0]] = data;
    if (sel == PWL_SEL_M  && addr < 4'd9) m_t[addr] = data;
    if (sel == PWL_SEL_C  && addr < 4'd9) c_t[addr] = data;
  endtask

  task automatic load_tables;
    logic [15:0] bps [8];
    bps = '{16'h8400, 16'h8200, 16'h8100, 16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0800};
    for (int i = 0; i < 8; i++) do_cfg(PWL_SEL_BP, 4'(i), bps[i]);
    for (int i = 0; i < 9; i++) do_cfg(PWL_SEL_M, 4'(i), 16'h0010 + 16'(i));
    for (int i = 0; i < 9; i++) do_cfg(PWL_SEL_C, 4'(i), 16'h0020 + 16'(i));
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    clear_model_tables();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    checks++; if (out_m !== 16'h0) begin failures++; $display("FAIL reset_out_m got=%h want=0000", out_m); end
    checks++; if (out_c !== 16'h0) begin failures++; $display("FAIL reset_out_c got=%h want=0000", out_c); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
    @(negedge clk);
  endtask

  task automatic test_latency;
    exp_t e;
    in_valid = 1'b1; in_data = 16'h8500; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b want=1", in_ready); end
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b want=0", out_valid); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn latency in=8500 data=%h m=%h c=%h", out_data, out_m, out_c);
      checks++; if (out_data !== e.d) begin failures++; $display("FAIL lat_data got=%h want=%h", out_data, e.d); end
      checks++; if (out_m !== 16'h0010) begin failures++; $display("FAIL lat_m got=%h want=0010", out_m); end
      checks++; if (out_c !== 16'h0020) begin failures++; $display("FAIL lat_c got=%h want=0020", out_c); end
`ifdef PWL_SEG_IDX_EN
      checks++; if (out_seg !== 4'd0) begin failures++; $display("FAIL lat_seg got=%0d want=0", out_seg); end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_segments;
    logic [15:0] vin [12];
    int          dir_seg [3];
    logic [15:0] x;
    exp_t        e;
    logic        got;
    vin = '{16'h0100, 16'h7FFF, 16'h8000, 16'h8400, 16'h83FF, 16'h0000,
            16'h07FF, 16'h0800, 16'h8100, 16'h80FF, 16'h01FF, 16'h8200};
    dir_seg = '{5, 8, 4};
    out_ready = 1'b1;
    for (int n = 0; n < 18; n++) begin
      x = (n < 12) ? vin[n] : 16'($urandom);
      in_valid = 1'b1; in_data = x;
      #1;
      if (in_valid && in_ready) sb.push_back(model(x));
      @(negedge clk);
      in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(negedge clk);
        #1;
        if (out_valid) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL seg_timeout in=%h got=no_output want=output", x); end
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn seg in=%h data=%h m=%h c=%h", x, out_data, out_m, out_c);
        checks++; if (out_data !== e.d) begin failures++; $display("FAIL seg_data in=%h got=%h want=%h", x, out_data, e.d); end
        checks++; if (out_m !== e.m) begin failures++; $display("FAIL seg_m in=%h got=%h want=%h", x, out_m, e.m); end
        checks++; if (out_c !== e.c) begin failures++; $display("FAIL seg_c in=%h got=%h want=%h", x, out_c, e.c); end
`ifdef PWL_SEG_IDX_EN
        checks++; if (out_seg !== e.seg) begin failures++; $display("FAIL seg_idx in=%h got=%0d want=%0d", x, out_seg, e.seg); end
`endif
        if (n < 3) begin
          checks++;
          if (out_m !== 16'h0010 + 16'(dir_seg[n])) begin
            failures++; $display("FAIL seg_directed in=%h got=%h want=%h", x, out_m, 16'h0010 + 16'(dir_seg[n]));
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] smp [8];
    int          sent = 0;
    int          recv = 0;
    logic        stalled = 1'b0;
    logic        saw_block = 1'b0;
    logic [15:0] pd, pm, pc;
    exp_t        e;
    pd = '0; pm = '0; pc = '0;
    for (int i = 0; i < 8; i++) smp[i] = (i % 2 == 0) ? 16'($urandom_range(0, 16'h0900)) : (16'h8000 | 16'($urandom_range(0, 16'h0500)));
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? smp[sent] : 16'h0;
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_m !== pm || out_c !== pc) begin
          failures++; $display("FAIL b2b_stall_hold got=%b/%h/%h/%h want=1/%h/%h/%h", out_valid, out_data, out_m, out_c, pd, pm, pc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra_output got=%h want=none", out_data);
        end else begin
          e = sb.pop_front();
          $display("txn b2b data=%h m=%h c=%h", out_data, out_m, out_c);
          if (out_data !== e.d || out_m !== e.m || out_c !== e.c) begin
            failures++; $display("FAIL b2b_result got=%h/%h/%h want=%h/%h/%h", out_data, out_m, out_c, e.d, e.m, e.c);
          end
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      pd = out_data; pm = out_m; pc = out_c;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv !== 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", recv); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL b2b_leftover got=%0d want=0", sb.size()); end
    checks++; if (saw_block !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_drop got=%b want=1", saw_block); end
    @(negedge clk);
  endtask

  task automatic test_cfg_busy;
    exp_t e;
    logic got;
    // Sample sits in S1 while a write is attempted.
    in_valid = 1'b1; in_data = 16'h0150; out_ready = 1'b0;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = PWL_SEL_M; cfg_addr = 4'd4; cfg_wdata = 16'h0999;
    #1;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_busy_ready got=%b want=0", cfg_ready); end
    @(negedge clk);
    cfg_we = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL cfg_drain_timeout got=no_output want=output"); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn cfg_old in=0150 m=%h c=%h", out_m, out_c);
      checks++; if (out_m !== e.m || out_c !== e.c) begin failures++; $display("FAIL cfg_old_result got=%h/%h want=%h/%h", out_m, out_c, e.m, e.c); end
    end
    @(negedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_idle_ready got=%b want=1", cfg_ready); end
    // Real write with a sample offered in the same cycle: sample must wait.
    cfg_we = 1'b1; cfg_sel = PWL_SEL_BP; cfg_addr = 4'd4; cfg_wdata = 16'h0180;
    in_valid = 1'b1; in_data = 16'h0150;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfg_write_in_ready got=%b want=0", in_ready); end
    bp_t[4] = 16'h0180;
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL cfg_new_timeout got=no_output want=output"); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn cfg_new in=0150 m=%h c=%h", out_m, out_c);
      checks++; if (out_m !== e.m || out_c !== e.c) begin failures++; $display("FAIL cfg_new_result got=%h/%h want=%h/%h", out_m, out_c, e.m, e.c); end
      checks++; if (out_m !== 16'h0014) begin failures++; $display("FAIL cfg_drop_m got=%h want=0014", out_m); end
    end
    @(negedge clk);
    // Reserved select and out-of-range address must not disturb segment 0.
    do_cfg(2'd3, 4'd0, 16'h7777);
    do_cfg(PWL_SEL_C, 4'd9, 16'h7777);
    do_cfg(PWL_SEL_M, 4'd15, 16'h7777);
    in_valid = 1'b1; in_data = 16'h8500;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn cfg_ignored in=8500 m=%h c=%h", out_m, out_c);
      checks++; if (out_valid !== 1'b1 || out_m !== 16'h0010 || out_c !== 16'h0020) begin
        failures++; $display("FAIL cfg_ignored got=%b/%h/%h want=1/0010/0020", out_valid, out_m, out_c);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    logic got;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0300;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_data = 16'h8050;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_state got=%b/%b want=1/0", out_valid, cfg_ready); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 16'h0 || out_m !== 16'h0 || out_c !== 16'h0) begin
      failures++; $display("FAIL rst_outputs got=%h/%h/%h want=0000/0000/0000", out_data, out_m, out_c);
    end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%b want=1", cfg_ready); end
    sb.delete();
    clear_model_tables();
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_stale got=%b want=0", out_valid); end
    in_valid = 1'b1; in_data = 16'h0123;
    #1;
    if (in_valid && in_ready) sb.push_back(model(in_data));
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL rst_after_timeout got=no_output want=output"); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn after_reset in=0123 data=%h m=%h c=%h", out_data, out_m, out_c);
      checks++; if (out_data !== e.d) begin failures++; $display("FAIL rst_after_data got=%h want=%h", out_data, e.d); end
      checks++; if (out_m !== 16'h0 || out_c !== 16'h0) begin failures++; $display("FAIL rst_after_mc got=%h/%h want=0000/0000", out_m, out_c); end
`ifdef PWL_SEG_IDX_EN
      checks++; if (out_seg !== 4'd8) begin failures++; $display("FAIL rst_after_seg got=%0d want=8", out_seg); end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    load_tables();
    test_latency();
    test_segments();
    test_back_to_back();
    test_cfg_busy();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
